sram_like_bridge: RTL and testbench

SRAM_LIKE_BRIDGE -- requirements
Module: sram_like_bridge

---
 rtl/sram_like_bridge_pkg.sv | 33 +++
 rtl/sram_like_bridge_if.sv | 24 ++
 rtl/sram_like_bridge_channel.sv | 94 +++++++++
 rtl/sram_like_bridge.sv | 70 +++++++
 tb/tb_sram_like_bridge.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_like_bridge_pkg.sv
// Shared definitions for the sram_like bridge: channel FSM states, bus
// transfer size codes and the byte-enable to size decoder.
package sram_like_bridge_pkg;

  typedef logic [1:0] size_t;

  // Channel FSM states; the encoding is fixed so it can be observed by debug.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } chan_state_e;

  localparam size_t SIZE_BYTE = 2'd0;
  localparam size_t SIZE_HALF = 2'd1;
  localparam size_t SIZE_WORD = 2'd2;

  // Loads (wen == 0) and full-word stores are word sized; aligned half-word
  // pairs are half; any single lane is a byte. Irregular patterns fall back
  // to word so the slave always sees a legal size code.
  function automatic size_t size_from_wen(input logic [3:0] wen);
    size_t size;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      4'b1111:                            size = SIZE_WORD;
      default:                            size = SIZE_WORD;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/sram_like_bridge_if.sv
// One sram_like bus port: request/address phase plus returned read data.
// The bridge is the master; the memory system is the slave.
interface sram_like_if;
  import sram_like_bridge_pkg::*;

  logic        req;
  logic        wr;
  size_t       size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_bridge_channel.sv
// One sram_like channel: request FSM plus a read-data buffer that holds the
// returned word until the whole pipeline is released.
module sram_like_channel
  import sram_like_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [31:0] addr_i,
  input  logic        wr_i,
  input  size_t       size_i,
  input  logic [31:0] wdata_i,
  input  logic        stall_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  sram_like_if.master bus
);

  chan_state_e state_q;
  logic [31:0] buf_q;
  logic        req_s;
  logic        data_hit_s;

  // Request and data-return qualification from the current state; data_ok
  // outside DATA belongs to no outstanding transfer and is ignored.
  always_comb begin
    req_s      = 1'b0;
    data_hit_s = 1'b0;
    case (state_q)
      ST_IDLE: req_s      = en_i;
      ST_ADDR: req_s      = 1'b1;
      ST_DATA: data_hit_s = bus.data_ok;
      ST_DONE: req_s      = 1'b0;
      default: req_s      = 1'b0;
    endcase
  end

  // Bus drive: address/attributes pass straight through, req is masked in reset.
  always_comb begin
    bus.addr  = addr_i;
    bus.wr    = wr_i;
    bus.size  = size_i;
    bus.wdata = wdata_i;
    if (rst) begin
      bus.req = 1'b0;
    end else begin
      bus.req = req_s;
    end
  end

  // Read data bypasses the buffer in the data_ok cycle; completion status for the stall.
  always_comb begin
    if (data_hit_s) begin
      rdata_o = bus.rdata;
    end else begin
      rdata_o = buf_q;
    end
    done_o = ~en_i | (state_q == ST_DONE) | data_hit_s;
  end

  // Channel FSM and read buffer; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      buf_q   <= 32'h0000_0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en_i) begin
            state_q <= bus.addr_ok ? ST_DATA : ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (bus.addr_ok) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus.data_ok) begin
            buf_q   <= bus.rdata;
            state_q <= stall_i ? ST_DONE : ST_IDLE;
          end
        end
        ST_DONE: begin
          if (!stall_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_bridge.sv
// Bridges the core's single-cycle SRAM ports onto two sram_like buses
// (instruction and data). Both channels run concurrently and the pipeline is
// stalled until each active channel has its data.
module sram_like_bridge
  import sram_like_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stall,
  sram_like_if.master inst_bus,
  sram_like_if.master data_bus
);

  logic  inst_done_s;
  logic  data_done_s;
  logic  data_wr_s;
  size_t data_size_s;

  // Store flag and transfer size from the byte enables.
  always_comb begin
    data_wr_s   = |data_sram_wen;
    data_size_s = size_from_wen(data_sram_wen);
  end

  // Pipeline stall: held in reset, else until both channels are done this cycle.
  always_comb begin
    if (rst) begin
      stall = 1'b1;
    end else begin
      stall = ~(inst_done_s & data_done_s);
    end
  end

  sram_like_channel u_inst (
    .clk     (clk),
    .rst     (rst),
    .en_i    (inst_sram_en),
    .addr_i  (inst_sram_addr),
    .wr_i    (1'b0),
    .size_i  (SIZE_WORD),
    .wdata_i (32'h0000_0000),
    .stall_i (stall),
    .rdata_o (inst_sram_rdata),
    .done_o  (inst_done_s),
    .bus     (inst_bus)
  );

  sram_like_channel u_data (
    .clk     (clk),
    .rst     (rst),
    .en_i    (data_sram_en),
    .addr_i  (data_sram_addr),
    .wr_i    (data_wr_s),
    .size_i  (data_size_s),
    .wdata_i (data_sram_wdata),
    .stall_i (stall),
    .rdata_o (data_sram_rdata),
    .done_o  (data_done_s),
    .bus     (data_bus)
  );

endmodule

// File: tb/tb_sram_like_bridge.sv
// Bench for sram_like_bridge: each pipeline step is described as a timeline
// (addr_ok delay, data_ok delay per channel) and the expected stall/req/rdata
// for every cycle of the step follows from that timeline.
module tb_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stall;

  sram_like_if inst_bus ();
  sram_like_if data_bus ();

  int n_checks = 0;
  int n_errors = 0;

  bit          cmp_en = 1'b0;
  logic        exp_stall, exp_ireq, exp_dreq, exp_dwr, exp_rel_i, exp_rel_d;
  logic [1:0]  exp_dsize;
  logic [31:0] exp_iaddr, exp_daddr, exp_dwdata, exp_irdata, exp_drdata;

  int          obs_stalls, obs_ireq_cycles, obs_dreq_cycles;
  logic [31:0] obs_irdata, obs_drdata, obs_daddr;
  logic        obs_dwr;
  logic [1:0]  obs_dsize;

  logic [3:0] wen_tab  [0:7] = '{4'b0000, 4'b1111, 4'b0011, 4'b1100,
                                 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [1:0] size_tab [0:7] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};

  always #5 clk = ~clk;

  sram_like_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stall           (stall),
    .inst_bus        (inst_bus),
    .data_bus        (data_bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT outputs against the timeline model every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("stall", {31'd0, stall}, {31'd0, exp_stall});
      chk("inst_req", {31'd0, inst_bus.req}, {31'd0, exp_ireq});
      chk("data_req", {31'd0, data_bus.req}, {31'd0, exp_dreq});
      if (exp_ireq) begin
        chk("inst_addr", inst_bus.addr, exp_iaddr);
        chk("inst_wr", {31'd0, inst_bus.wr}, 32'd0);
        chk("inst_size", {30'd0, inst_bus.size}, 32'd2);
      end
      if (exp_dreq) begin
        chk("data_addr", data_bus.addr, exp_daddr);
        chk("data_wr", {31'd0, data_bus.wr}, {31'd0, exp_dwr});
        chk("data_size", {30'd0, data_bus.size}, {30'd0, exp_dsize});
        if (exp_dwr) chk("data_wdata", data_bus.wdata, exp_dwdata);
      end
      if (exp_rel_i) chk("inst_sram_rdata", inst_sram_rdata, exp_irdata);
      if (exp_rel_d) chk("data_sram_rdata", data_sram_rdata, exp_drdata);
    end
  end

  // One pipeline step: channel data_ok lands at (addr_ok delay + data delay);
  // the release cycle is the latest of those among active channels.
  task automatic do_step(input bit i_act, input logic [31:0] ia, input logic [31:0] ird,
                         input int ai, input int di,
                         input bit d_act, input int widx, input logic [31:0] da,
                         input logic [31:0] wd, input logic [31:0] drd,
                         input int ad, input int dd);
    int ti, td, r;
    ti = ai + di;
    td = ad + dd;
    r  = 0;
    if (i_act && ti > r) r = ti;
    if (d_act && td > r) r = td;
    obs_stalls = 0; obs_ireq_cycles = 0; obs_dreq_cycles = 0;
    for (int k = 0; k <= r; k++) begin
      @(posedge clk); #1;
      rst             = 1'b0;
      inst_sram_en    = i_act;
      inst_sram_addr  = ia;
      data_sram_en    = d_act;
      data_sram_wen   = wen_tab[widx];
      data_sram_addr  = da;
      data_sram_wdata = wd;
      inst_bus.addr_ok = i_act && (k == ai);
      inst_bus.data_ok = i_act && ((k == ti) || ((k < ai) && ($urandom_range(0, 1) == 1)));
      inst_bus.rdata   = (k == ti) ? ird : $urandom();
      data_bus.addr_ok = d_act && (k == ad);
      data_bus.data_ok = d_act && ((k == td) || ((k < ad) && ($urandom_range(0, 1) == 1)));
      data_bus.rdata   = (k == td) ? drd : $urandom();
      exp_stall  = (k < r);
      exp_ireq   = i_act && (k <= ai);
      exp_dreq   = d_act && (k <= ad);
      exp_iaddr  = ia;
      exp_daddr  = da;
      exp_dwdata = wd;
      exp_dwr    = (wen_tab[widx] != 4'b0000);
      exp_dsize  = size_tab[widx];
      exp_rel_i  = i_act && (k == r);
      exp_rel_d  = d_act && (k == r);
      exp_irdata = ird;
      exp_drdata = drd;
      cmp_en     = 1'b1;
      @(negedge clk);
      if (stall) obs_stalls++;
      if (inst_bus.req) obs_ireq_cycles++;
      if (data_bus.req) obs_dreq_cycles++;
      if (k == 0) begin
        obs_dwr   = data_bus.wr;
        obs_dsize = data_bus.size;
        obs_daddr = data_bus.addr;
      end
      if (k == r) begin
        obs_irdata = inst_sram_rdata;
        obs_drdata = data_sram_rdata;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    inst_sram_en = 1'b1; inst_sram_addr = 32'h0; data_sram_en = 1'b1;
    data_sram_wen = 4'b0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    inst_bus.addr_ok = 1'b0; inst_bus.data_ok = 1'b0; inst_bus.rdata = 32'h0;
    data_bus.addr_ok = 1'b0; data_bus.data_ok = 1'b0; data_bus.rdata = 32'h0;

    // Reset with both channels requesting: no req, stall held, buffers clear.
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      inst_sram_en = 1'b1; data_sram_en = 1'b1;
      inst_bus.addr_ok = 1'b1;
      exp_stall = 1'b1; exp_ireq = 1'b0; exp_dreq = 1'b0;
      exp_rel_i = (n > 0); exp_rel_d = (n > 0);
      exp_irdata = 32'h0; exp_drdata = 32'h0;
      cmp_en = 1'b1;
    end

    // Minimum-latency fetch, data port idle.
    do_step(1'b1, 32'hBFC0_0000, 32'h2401_0001, 0, 1, 1'b0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
    chk("fetch_stall_cycles", obs_stalls, 32'd1);
    chk("fetch_rdata", obs_irdata, 32'h2401_0001);

    // Half-word store alongside a fetch.
    do_step(1'b1, 32'hBFC0_0004, 32'h0000_0000, 0, 1,
            1'b1, 2, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 0, 1);
    chk("store_wr", {31'd0, obs_dwr}, 32'd1);
    chk("store_size", {30'd0, obs_dsize}, 32'd1);
    chk("store_addr", obs_daddr, 32'h8000_0002);

    // Inst data_ok at cycle 2, load data_ok at cycle 5.
    do_step(1'b1, 32'hBFC0_0008, 32'h3C1D_BFC0, 0, 2,
            1'b1, 0, 32'h8000_0100, 32'h0, 32'h1122_3344, 1, 4);
    chk("overlap_stall_cycles", obs_stalls, 32'd5);
    chk("overlap_inst_rdata", obs_irdata, 32'h3C1D_BFC0);
    chk("overlap_data_rdata", obs_drdata, 32'h1122_3344);

    // Delayed addr_ok, instruction-only.
    do_step(1'b1, 32'hBFC0_000C, 32'hCAFE_0001, 2, 1, 1'b0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
    chk("delay_req_cycles", obs_ireq_cycles, 32'd3);
    chk("inst_only_data_req", obs_dreq_cycles, 32'd0);
    chk("inst_only_stalls", obs_stalls, 32'd3);

    // Reset while the fetch waits in DATA; a late data_ok must not land.
    @(posedge clk); #1;
    rst = 1'b0; inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0010; data_sram_en = 1'b0;
    inst_bus.addr_ok = 1'b1; inst_bus.data_ok = 1'b0;
    exp_stall = 1'b1; exp_ireq = 1'b1; exp_dreq = 1'b0; exp_iaddr = 32'hBFC0_0010;
    exp_rel_i = 1'b0; exp_rel_d = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; inst_bus.addr_ok = 1'b0;
    exp_ireq = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall", {31'd0, stall}, 32'd1);
    chk("rst_mid_req", {31'd0, inst_bus.req}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; inst_sram_en = 1'b0;
    inst_bus.data_ok = 1'b1; inst_bus.rdata = 32'hDEAD_BEEF;
    exp_stall = 1'b0; exp_rel_i = 1'b1; exp_rel_d = 1'b1;
    exp_irdata = 32'h0; exp_drdata = 32'h0;
    @(negedge clk);
    chk("late_data_ok_ignored", inst_sram_rdata, 32'h0);

    // Randomized steps.
    for (int s = 0; s < 80; s++) begin
      do_step($urandom_range(0, 3) != 0, $urandom(), $urandom(),
              $urandom_range(0, 3), $urandom_range(1, 4),
              $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom(), $urandom(), $urandom(),
              $urandom_range(0, 3), $urandom_range(1, 4));
    end

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
